// File: rtl/avalon_io_pkg.sv
// avalon_io_pkg: shared state encodings, constants and request payload for the
// Avalon I/O byte responder. The optional per-byte timeout is IO_TIMEOUT_EN.
package avalon_io_pkg;

  localparam int unsigned IO_TIMEOUT_W    = 8;
  localparam logic [7:0]  IO_LANE_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BYTE   = 3'd1,
    ST_NEXT   = 3'd2,
    ST_R_RESP = 3'd3,
    ST_W_DONE = 3'd4
  } io_state_e;

  // Captured copy of the accepted Avalon request; mask bits clear as lanes finish.
  typedef struct packed {
    logic        is_write;
    logic [13:0] addr_dw;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } io_req_t;

endpackage

// File: rtl/io_lane_pick.sv
// io_lane_pick: lowest-set-lane finder used to serialize byte lanes in ascending order.
module io_lane_pick (
  input  logic [3:0] mask,
  output logic [1:0] lane_c,
  output logic       any_c
);

  // Priority encode the lowest set lane; lane 0 wins.
  always_comb begin
    lane_c = 2'd0;
    if      (mask[0]) lane_c = 2'd0;
    else if (mask[1]) lane_c = 2'd1;
    else if (mask[2]) lane_c = 2'd2;
    else if (mask[3]) lane_c = 2'd3;
  end

  assign any_c = |mask;

endmodule

// File: rtl/avalon_io_byte_responder.sv
// avalon_io_byte_responder: Avalon-MM I/O slave that splits each dword access into
// byte accesses on an 8-bit legacy device bus. Define IO_TIMEOUT_EN to abandon a
// byte after TIMEOUT_CYCLES without io_dev_ack.
module avalon_io_byte_responder
  import avalon_io_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] avalon_io_address,
  input  logic [3:0]  avalon_io_byteenable,
  input  logic        avalon_io_read,
  input  logic        avalon_io_write,
  input  logic [31:0] avalon_io_writedata,
  output logic [31:0] avalon_io_readdata,
  output logic        avalon_io_readdatavalid,
  output logic        avalon_io_waitrequest,
  output logic [15:0] io_dev_address,
  output logic        io_dev_read,
  output logic        io_dev_write,
  output logic [7:0]  io_dev_writedata,
  input  logic [7:0]  io_dev_readdata,
  input  logic        io_dev_ack
);

  io_state_e   state;
  io_req_t     req_q;
  logic [1:0]  lane_q;
  logic [31:0] buf_q;

  logic        in_idle_c;
  logic        start_c;
  logic        go_write_c;
  logic [3:0]  pick_mask_c;
  logic [1:0]  pick_lane_c;
  logic        any_c;
  logic [13:0] src_addr_c;
  logic [31:0] src_wdata_c;
  logic        timeout_hit_c;
  logic        unused_addr_bits;

  // In IDLE the next lane comes straight from the bus; afterwards from the captured copy.
  assign in_idle_c   = (state == ST_IDLE);
  assign start_c     = avalon_io_write | avalon_io_read;
  assign go_write_c  = in_idle_c ? avalon_io_write      : req_q.is_write;
  assign pick_mask_c = in_idle_c ? avalon_io_byteenable : req_q.mask;
  assign src_addr_c  = in_idle_c ? avalon_io_address[15:2] : req_q.addr_dw;
  assign src_wdata_c = in_idle_c ? avalon_io_writedata  : req_q.wdata;

  // Reads are taken in IDLE; writes stall until every byte has completed.
  assign avalon_io_waitrequest = in_idle_c ? avalon_io_write : (state != ST_W_DONE);

  // Address bits [1:0] are don't-care; lanes come from byteenable.
  assign unused_addr_bits = ^avalon_io_address[1:0];

  io_lane_pick u_lane_pick (
    .mask   (pick_mask_c),
    .lane_c (pick_lane_c),
    .any_c  (any_c)
  );

`ifdef IO_TIMEOUT_EN
  logic [IO_TIMEOUT_W-1:0] tmo_cnt_q;

  assign timeout_hit_c = (tmo_cnt_q == IO_TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Per-byte wait counter: held at zero outside BYTE, counts un-acked BYTE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state != ST_BYTE) begin
      tmo_cnt_q <= '0;
    end else if (!io_dev_ack) begin
      tmo_cnt_q <= tmo_cnt_q + IO_TIMEOUT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit_c      = 1'b0;
  assign unused_timeout_cfg = ^IO_TIMEOUT_W'(TIMEOUT_CYCLES);
`endif

  // Main sequencer: capture, launch one byte per BYTE/NEXT pair, then respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_IDLE;
      req_q                   <= '0;
      lane_q                  <= 2'd0;
      buf_q                   <= '1;
      avalon_io_readdata      <= '1;
      avalon_io_readdatavalid <= 1'b0;
      io_dev_address          <= '0;
      io_dev_read             <= 1'b0;
      io_dev_write            <= 1'b0;
      io_dev_writedata        <= '0;
    end else begin
      avalon_io_readdatavalid <= 1'b0;
      case (state)
        ST_IDLE, ST_NEXT: begin
          if (in_idle_c && start_c) begin
            req_q <= '{is_write: avalon_io_write,
                       addr_dw:  avalon_io_address[15:2],
                       mask:     avalon_io_byteenable,
                       wdata:    avalon_io_writedata};
            buf_q <= {4{IO_LANE_DEFAULT}};
          end
          if (!in_idle_c || start_c) begin
            if (any_c) begin
              state            <= ST_BYTE;
              lane_q           <= pick_lane_c;
              io_dev_address   <= {src_addr_c, pick_lane_c};
              io_dev_read      <= ~go_write_c;
              io_dev_write     <= go_write_c;
              io_dev_writedata <= go_write_c ? src_wdata_c[{pick_lane_c, 3'b000} +: 8] : 8'h00;
            end else if (go_write_c) begin
              state <= ST_W_DONE;
            end else begin
              state                   <= ST_R_RESP;
              avalon_io_readdatavalid <= 1'b1;
              avalon_io_readdata      <= in_idle_c ? {4{IO_LANE_DEFAULT}} : buf_q;
            end
          end
        end
        ST_BYTE: begin
          if (io_dev_ack || timeout_hit_c) begin
            if (io_dev_ack && !req_q.is_write) begin
              buf_q[{lane_q, 3'b000} +: 8] <= io_dev_readdata;
            end
            req_q.mask[lane_q] <= 1'b0;
            io_dev_read        <= 1'b0;
            io_dev_write       <= 1'b0;
            state              <= ST_NEXT;
          end
        end
        ST_R_RESP: state <= ST_IDLE;
        ST_W_DONE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_io_byte_responder.sv
// Bench for avalon_io_byte_responder: directed vector table, corner sequences
// (stall/timeout, reset mid-access) and randomized traffic against a byte-memory model.
module tb_avalon_io_byte_responder;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] avalon_io_address;
  logic [3:0]  avalon_io_byteenable;
  logic        avalon_io_read;
  logic        avalon_io_write;
  logic [31:0] avalon_io_writedata;
  logic [31:0] avalon_io_readdata;
  logic        avalon_io_readdatavalid;
  logic        avalon_io_waitrequest;
  logic [15:0] io_dev_address;
  logic        io_dev_read;
  logic        io_dev_write;
  logic [7:0]  io_dev_writedata;
  logic [7:0]  io_dev_readdata;
  logic        io_dev_ack;

  avalon_io_byte_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .avalon_io_address       (avalon_io_address),
    .avalon_io_byteenable    (avalon_io_byteenable),
    .avalon_io_read          (avalon_io_read),
    .avalon_io_write         (avalon_io_write),
    .avalon_io_writedata     (avalon_io_writedata),
    .avalon_io_readdata      (avalon_io_readdata),
    .avalon_io_readdatavalid (avalon_io_readdatavalid),
    .avalon_io_waitrequest   (avalon_io_waitrequest),
    .io_dev_address          (io_dev_address),
    .io_dev_read             (io_dev_read),
    .io_dev_write            (io_dev_write),
    .io_dev_writedata        (io_dev_writedata),
    .io_dev_readdata         (io_dev_readdata),
    .io_dev_ack              (io_dev_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Device memory (what the device holds) and reference memory (what the model predicts).
  logic [7:0] dev_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    bit          is_wr;
    int          cyc;
  } xact_t;

  xact_t dev_log[$];
  int    ack_lat;
  bit    never_ack;
  int    strobe_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          lat_cfg;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Legacy device: acks after ack_lat extra strobe cycles, logs each byte access once.
  initial begin
    xact_t x;
    io_dev_ack      = 1'b0;
    io_dev_readdata = 8'h00;
    strobe_cnt      = 0;
    forever begin
      @(negedge clk);
      if (io_dev_read || io_dev_write) begin
        if (strobe_cnt == 0) begin
          x.addr  = io_dev_address;
          x.data  = io_dev_write ? io_dev_writedata : dev_mem[io_dev_address];
          x.is_wr = io_dev_write;
          x.cyc   = cyc;
          dev_log.push_back(x);
        end
        io_dev_ack      = !never_ack && (strobe_cnt >= ack_lat);
        io_dev_readdata = dev_mem[io_dev_address];
        if (io_dev_ack && io_dev_write) dev_mem[io_dev_address] = io_dev_writedata;
        strobe_cnt++;
      end else begin
        io_dev_ack = 1'b0;
        strobe_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [15:0] a, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? ref_mem[{a[15:2], 2'(i)}] : 8'hFF;
    return r;
  endfunction

  task automatic preset(input logic [15:0] a, input logic [7:0] v);
    dev_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic chk_log(input string name, input bit wr, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input int gap);
    int k;
    logic [15:0] ea;
    logic [7:0]  ed;
    chk({name, "_nbytes"}, 32'(dev_log.size()), 32'($countones(be)));
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (be[i] && k < dev_log.size()) begin
        ea = {a[15:2], 2'(i)};
        ed = wr ? wd[8*i +: 8] : ref_mem[ea];
        chk({name, "_addr"}, 32'(dev_log[k].addr), 32'(ea));
        chk({name, "_data"}, 32'(dev_log[k].data), 32'(ed));
        chk({name, "_dir"},  32'(dev_log[k].is_wr), 32'(wr));
        if (k > 0 && gap > 0)
          chk({name, "_gap"}, 32'(dev_log[k].cyc - dev_log[k-1].cyc), 32'(gap));
        k++;
      end
    end
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [3:0] be,
                          output logic [31:0] d, output int lat);
    @(negedge clk);
    avalon_io_address    = a;
    avalon_io_byteenable = be;
    avalon_io_read       = 1'b1;
    #1 chk("rd_accept_wrq", 32'(avalon_io_waitrequest), 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      avalon_io_read       = 1'b0;
      avalon_io_address    = 16'($urandom);
      avalon_io_byteenable = 4'($urandom);
    end while (!avalon_io_readdatavalid && lat < 500);
    d = avalon_io_readdata;
    @(negedge clk);
    chk("rdv_pulse", 32'(avalon_io_readdatavalid), 32'd0);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [3:0] be,
                           input logic [31:0] wd, output int lat);
    @(negedge clk);
    avalon_io_address    = a;
    avalon_io_byteenable = be;
    avalon_io_writedata  = wd;
    avalon_io_write      = 1'b1;
    #1 chk("wr_stall", 32'(avalon_io_waitrequest), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      avalon_io_address    = 16'($urandom);
      avalon_io_byteenable = 4'($urandom);
      avalon_io_writedata  = $urandom;
    end while (avalon_io_waitrequest && lat < 500);
    @(negedge clk);
    avalon_io_write = 1'b0;
  endtask

  task automatic run_one(input string name, input bit wr, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input int l,
                         output logic [31:0] d, output int lat);
    ack_lat = l;
    dev_log.delete();
    d = '0;
    if (wr) bus_write(a, be, wd, lat);
    else    bus_read(a, be, d, lat);
    chk_log(name, wr, a, be, wd, l + 2);
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[{a[15:2], 2'(i)}] = wd[8*i +: 8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, wd, exp_d;
    logic [15:0] a;
    logic [3:0]  be;
    int          lat, l, exp_lat;
    bit          wr, seen;

    rst_n = 1'b0;
    avalon_io_address = '0; avalon_io_byteenable = '0; avalon_io_read = 1'b0;
    avalon_io_write = 1'b0; avalon_io_writedata = '0;
    never_ack = 1'b0; ack_lat = 0;
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    preset(16'h0060, 8'hA5);
    preset(16'h0100, 8'h01); preset(16'h0101, 8'h02);
    preset(16'h0102, 8'h03); preset(16'h0103, 8'h04);
    preset(16'h0062, 8'h7E);

    vecs[0] = '{1'b0, 16'h0060, 4'b0001, 32'h0,        0, 32'hFFFFFFA5, 3};
    vecs[1] = '{1'b1, 16'h03F4, 4'b1010, 32'h11223344, 0, 32'h0,        5};
    vecs[2] = '{1'b0, 16'h0100, 4'b1111, 32'h0,        2, 32'h04030201, 17};
    vecs[3] = '{1'b0, 16'h0200, 4'b0000, 32'h0,        0, 32'hFFFFFFFF, 1};
    vecs[4] = '{1'b1, 16'h0300, 4'b0000, 32'hDEADBEEF, 0, 32'h0,        1};
    vecs[5] = '{1'b0, 16'h0063, 4'b0100, 32'h0,        1, 32'hFF7EFFFF, 4};
    vecs[6] = '{1'b0, 16'h03F4, 4'b1010, 32'h0,        0, 32'h11FF33FF, 5};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rdata", avalon_io_readdata, 32'hFFFFFFFF);
    chk("rst_rdv",   32'(avalon_io_readdatavalid), 32'd0);
    chk("rst_wrq",   32'(avalon_io_waitrequest), 32'd0);
    chk("rst_strb",  32'({io_dev_read, io_dev_write}), 32'd0);
    chk("rst_daddr", 32'(io_dev_address), 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int v = 0; v < 7; v++) begin
      run_one($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].be,
              vecs[v].wd, vecs[v].lat_cfg, d, lat);
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      if (!vecs[v].wr) chk($sformatf("vec%0d_rdata", v), d, vecs[v].exp_rdata);
    end

`ifdef IO_TIMEOUT_EN
    // Device never acks: each lane is abandoned after TO cycles and reads 0xFF.
    never_ack = 1'b1; ack_lat = 0; dev_log.delete();
    bus_read(16'h0440, 4'b0011, d, lat);
    chk("tmo_lat",   32'(lat), 32'(2 * (TO + 1) + 1));
    chk("tmo_rdata", d, 32'hFFFFFFFF);
    chk("tmo_lanes", 32'(dev_log.size()), 32'd2);
    never_ack = 1'b0;
`else
    // Device never acks: the responder must stall in the first byte.
    never_ack = 1'b1; ack_lat = 0; dev_log.delete();
    @(negedge clk);
    avalon_io_address = 16'h0440; avalon_io_byteenable = 4'b0011; avalon_io_read = 1'b1;
    @(negedge clk);
    avalon_io_read = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (avalon_io_readdatavalid) seen = 1'b1;
    end
    chk("stall_no_rdv", 32'(seen), 32'd0);
    chk("stall_strobe", 32'(io_dev_read), 32'd1);
    chk("stall_addr",   32'(io_dev_address), 32'h0440);
    never_ack = 1'b0;
    lat = 0;
    while (!avalon_io_readdatavalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_release_rdv", 32'(avalon_io_readdatavalid), 32'd1);
    chk("stall_release_rdata", avalon_io_readdata, model_read(16'h0440, 4'b0011));
    @(negedge clk);
`endif

    // Reset in the middle of a write byte
    never_ack = 1'b1; dev_log.delete();
    @(negedge clk);
    avalon_io_address = 16'h0500; avalon_io_byteenable = 4'b1111;
    avalon_io_writedata = 32'hCAFEF00D; avalon_io_write = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_pre_strobe", 32'(io_dev_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_strb",  32'({io_dev_read, io_dev_write}), 32'd0);
    chk("rstmid_daddr", 32'(io_dev_address), 32'd0);
    chk("rstmid_dwd",   32'(io_dev_writedata), 32'd0);
    chk("rstmid_rdv",   32'(avalon_io_readdatavalid), 32'd0);
    chk("rstmid_rdata", avalon_io_readdata, 32'hFFFFFFFF);
    avalon_io_write = 1'b0;
    #1 chk("rstmid_wrq", 32'(avalon_io_waitrequest), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; never_ack = 1'b0;
    run_one("post_rst", 1'b0, 16'h0500, 4'b1111, 32'h0, 0, d, lat);
    chk("post_rst_lat",   32'(lat), 32'd9);
    chk("post_rst_rdata", d, model_read(16'h0500, 4'b1111));

    // Randomized traffic in a small window so reads revisit earlier writes
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = {8'h04, 6'($urandom), 2'($urandom)};
      be = 4'($urandom);
      wd = $urandom;
      l  = int'($urandom_range(0, 3));
      exp_d   = model_read(a, be);
      exp_lat = $countones(be) * (l + 2) + 1;
      run_one("rand", wr, a, be, wd, l, d, lat);
      chk("rand_lat", 32'(lat), 32'(exp_lat));
      if (!wr) chk("rand_rdata", d, exp_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
